// File: rtl/fft_radix2_stream.sv
// rtl/fft_radix2_stream.sv - iterative radix-2 DIT FFT with streaming load and natural-order unload
module fft_radix2_stream #(
   parameter int WIDTH = 16,
   parameter int LOG2N = 3,
   parameter int SCALE = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_re,
   input  logic signed [WIDTH-1:0] in_im,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] out_re,
   output logic signed [WIDTH-1:0] out_im,
   output logic [LOG2N-1:0]        out_index,
   output logic                    busy,
   output logic                    done
);

   localparam int N  = 1 << LOG2N;
   localparam int AW = LOG2N;
   localparam int BW = LOG2N - 1;
   localparam int EW = WIDTH + 1;
   localparam int PW = WIDTH + 17;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_UNLOAD} state_t;

   state_t                  state_q, state_d;
   logic [AW-1:0]           cnt_q, cnt_d;
   logic [1:0]              stage_q, stage_d;
   logic [BW-1:0]           bfly_q, bfly_d;
   logic                    done_q, done_d;
   logic signed [WIDTH-1:0] mem_re_q [N];
   logic signed [WIDTH-1:0] mem_im_q [N];
   logic signed [WIDTH-1:0] mem_re_d [N];
   logic signed [WIDTH-1:0] mem_im_d [N];

   // butterfly datapath signals
   logic [AW-1:0]           j_ext, h_vec, grp, off, addr_a, addr_b;
   logic [2:0]              tw_sel;
   logic signed [15:0]      w_re, w_im;
   logic signed [PW-1:0]    b_re_x, b_im_x, w_re_x, w_im_x;
   logic signed [PW-1:0]    t_re_full, t_im_full;
   logic signed [EW-1:0]    t_re, t_im, a_re_x, a_im_x;
   logic signed [EW-1:0]    sum_re, sum_im, dif_re, dif_im;
   logic signed [WIDTH-1:0] bf_a_re, bf_a_im, bf_b_re, bf_b_im;

   function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] v);
      for (int i = 0; i < AW; i++) begin
         bit_rev[i] = v[AW-1-i];
      end
   endfunction

   // W^k for a 16-point transform, Q1.14, imaginary part is -sin
   function automatic logic [31:0] twiddle(input logic [2:0] k);
      logic signed [15:0] wr, wi;
      case (k)
         3'd0:    begin wr = 16'sd16384;  wi = 16'sd0;      end
         3'd1:    begin wr = 16'sd15137;  wi = -16'sd6270;  end
         3'd2:    begin wr = 16'sd11585;  wi = -16'sd11585; end
         3'd3:    begin wr = 16'sd6270;   wi = -16'sd15137; end
         3'd4:    begin wr = 16'sd0;      wi = -16'sd16384; end
         3'd5:    begin wr = -16'sd6270;  wi = -16'sd15137; end
         3'd6:    begin wr = -16'sd11585; wi = -16'sd11585; end
         default: begin wr = -16'sd15137; wi = -16'sd6270;  end
      endcase
      twiddle = {wr, wi};
   endfunction

   // operand addressing, twiddle lookup and the butterfly arithmetic for the current (stage, j)
   always_comb begin
      j_ext  = AW'(bfly_q);
      h_vec  = AW'(1) << stage_q;
      off    = j_ext & (h_vec - AW'(1));
      grp    = j_ext >> stage_q;
      addr_a = ((grp << stage_q) << 1) | off;
      addr_b = addr_a | h_vec;
      // k * 16/N collapses to m << (3 - s) for every legal N
      tw_sel = 3'(off) << (2'd3 - stage_q);
      {w_re, w_im} = twiddle(tw_sel);

      b_re_x = PW'(mem_re_q[addr_b]);
      b_im_x = PW'(mem_im_q[addr_b]);
      w_re_x = PW'(w_re);
      w_im_x = PW'(w_im);
      t_re_full = b_re_x * w_re_x - b_im_x * w_im_x;
      t_im_full = b_re_x * w_im_x + b_im_x * w_re_x;
      t_re = EW'(t_re_full >>> 14);
      t_im = EW'(t_im_full >>> 14);

      a_re_x = EW'(mem_re_q[addr_a]);
      a_im_x = EW'(mem_im_q[addr_a]);
      sum_re = a_re_x + t_re;
      sum_im = a_im_x + t_im;
      dif_re = a_re_x - t_re;
      dif_im = a_im_x - t_im;

      bf_a_re = (SCALE != 0) ? WIDTH'(sum_re >>> 1) : WIDTH'(sum_re);
      bf_a_im = (SCALE != 0) ? WIDTH'(sum_im >>> 1) : WIDTH'(sum_im);
      bf_b_re = (SCALE != 0) ? WIDTH'(dif_re >>> 1) : WIDTH'(dif_re);
      bf_b_im = (SCALE != 0) ? WIDTH'(dif_im >>> 1) : WIDTH'(dif_im);
   end

   // next-state, counters and register-file updates
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stage_d  = stage_q;
      bfly_d   = bfly_q;
      done_d   = 1'b0;
      mem_re_d = mem_re_q;
      mem_im_d = mem_im_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               cnt_d   = '0;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               mem_re_d[bit_rev(cnt_q)] = in_re;
               mem_im_d[bit_rev(cnt_q)] = in_im;
               cnt_d = cnt_q + AW'(1);
               if (cnt_q == AW'(N - 1)) begin
                  state_d = S_CALC;
                  stage_d = '0;
                  bfly_d  = '0;
               end
            end
         end
         S_CALC: begin
            mem_re_d[addr_a] = bf_a_re;
            mem_im_d[addr_a] = bf_a_im;
            mem_re_d[addr_b] = bf_b_re;
            mem_im_d[addr_b] = bf_b_im;
            if (bfly_q == BW'(N / 2 - 1)) begin
               bfly_d = '0;
               if (stage_q == 2'(LOG2N - 1)) begin
                  state_d = S_UNLOAD;
                  stage_d = '0;
                  cnt_d   = '0;
               end else begin
                  stage_d = stage_q + 2'd1;
               end
            end else begin
               bfly_d = bfly_q + BW'(1);
            end
         end
         S_UNLOAD: begin
            if (out_ready) begin
               cnt_d = cnt_q + AW'(1);
               if (cnt_q == AW'(N - 1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // control registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         stage_q <= '0;
         bfly_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         bfly_q  <= bfly_d;
         done_q  <= done_d;
      end
   end

   // register file; contents are meaningless after reset so it is not cleared
   always_ff @(posedge clk) begin
      mem_re_q <= mem_re_d;
      mem_im_q <= mem_im_d;
   end

   assign in_ready  = (state_q == S_LOAD);
   assign out_valid = (state_q == S_UNLOAD);
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign out_index = out_valid ? cnt_q : '0;
   assign out_re    = out_valid ? mem_re_q[cnt_q] : '0;
   assign out_im    = out_valid ? mem_im_q[cnt_q] : '0;

endmodule

// File: tb/tb_fft_radix2_stream.sv
// tb/tb_fft_radix2_stream.sv - directed checks of fft_radix2_stream across four parameter sets
module tb_fft_radix2_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst, in_valid, out_ready;
   logic               start_v [4];
   logic signed [15:0] in_re, in_im;
   logic               ir [4];
   logic               ov [4];
   logic               busy [4];
   logic               done [4];
   logic signed [15:0] ore [4];
   logic signed [15:0] oim [4];
   logic [3:0]         oidx [4];

   logic signed [15:0] re0, im0, re1, im1;
   logic signed [11:0] re2, im2, re3, im3;
   logic [2:0]         idx0, idx1;
   logic [1:0]         idx2;
   logic [3:0]         idx3;

   assign ore[0] = re0;
   assign oim[0] = im0;
   assign ore[1] = re1;
   assign oim[1] = im1;
   assign ore[2] = {{4{re2[11]}}, re2};
   assign oim[2] = {{4{im2[11]}}, im2};
   assign ore[3] = {{4{re3[11]}}, re3};
   assign oim[3] = {{4{im3[11]}}, im3};
   assign oidx[0] = {1'b0, idx0};
   assign oidx[1] = {1'b0, idx1};
   assign oidx[2] = {2'b00, idx2};
   assign oidx[3] = idx3;

   fft_radix2_stream #(.WIDTH(16), .LOG2N(3), .SCALE(0)) u_d0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid), .in_ready(ir[0]),
      .in_re(in_re), .in_im(in_im), .out_valid(ov[0]), .out_ready(out_ready),
      .out_re(re0), .out_im(im0), .out_index(idx0), .busy(busy[0]), .done(done[0]));

   fft_radix2_stream #(.WIDTH(16), .LOG2N(3), .SCALE(1)) u_d1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid), .in_ready(ir[1]),
      .in_re(in_re), .in_im(in_im), .out_valid(ov[1]), .out_ready(out_ready),
      .out_re(re1), .out_im(im1), .out_index(idx1), .busy(busy[1]), .done(done[1]));

   fft_radix2_stream #(.WIDTH(12), .LOG2N(2), .SCALE(0)) u_d2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid), .in_ready(ir[2]),
      .in_re(in_re[11:0]), .in_im(in_im[11:0]), .out_valid(ov[2]), .out_ready(out_ready),
      .out_re(re2), .out_im(im2), .out_index(idx2), .busy(busy[2]), .done(done[2]));

   fft_radix2_stream #(.WIDTH(12), .LOG2N(4), .SCALE(1)) u_d3 (
      .clk(clk), .rst(rst), .start(start_v[3]), .in_valid(in_valid), .in_ready(ir[3]),
      .in_re(in_re[11:0]), .in_im(in_im[11:0]), .out_valid(ov[3]), .out_ready(out_ready),
      .out_re(re3), .out_im(im3), .out_index(idx3), .busy(busy[3]), .done(done[3]));

   int    cyc = 0;
   int    n_chk = 0;
   int    n_fail = 0;
   string test_name = "reset";
   int    xr [16];
   int    xi [16];
   int    er [16];
   int    ei [16];

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached in %s", test_name);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got %0d, expected %0d", test_name, tag, got, exp);
      end
   endtask

   task automatic clear_vec();
      for (int i = 0; i < 16; i++) begin
         xr[i] = 0; xi[i] = 0; er[i] = 0; ei[i] = 0;
      end
   endtask

   task automatic run_fft(input int d, input int lg, input bit stall, input bit started,
                          input bit chain, input bit abort);
      int npts, guard, t_in, dcnt;
      npts = 1 << lg;
      t_in = 0;
      if (!started) begin
         start_v[d] = 1'b1;
         @(posedge clk); #1;
         start_v[d] = 1'b0;
      end
      check_eq("busy_in_load", busy[d], 1);
      check_eq("in_ready_in_load", ir[d], 1);
      for (int n = 0; n < npts; n++) begin
         if (stall && (n == 2 || $urandom_range(0, 2) == 0)) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
         end
         in_valid = 1'b1;
         in_re = 16'(xr[n]);
         in_im = 16'(xi[n]);
         guard = 0;
         while (!ir[d] && guard < 50) begin @(posedge clk); #1; guard++; end
         check_eq("load_accept", ir[d], 1);
         t_in = cyc;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check_eq("in_ready_drop", ir[d], 0);
      if (abort) begin
         repeat (5) begin @(posedge clk); #1; end
         check_eq("busy_in_stage1", busy[d], 1);
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         check_eq("busy_after_rst", busy[d], 0);
         check_eq("done_after_rst", done[d], 0);
         check_eq("valid_after_rst", ov[d], 0);
         dcnt = 0;
         repeat (20) begin
            @(posedge clk); #1;
            if (done[d] || busy[d]) dcnt++;
         end
         check_eq("quiet_after_rst", dcnt, 0);
      end else begin
         guard = 0;
         while (!ov[d] && guard < 300) begin
            start_v[d] = stall && (guard == 2);
            @(posedge clk); #1;
            guard++;
         end
         start_v[d] = 1'b0;
         check_eq("out_valid_seen", ov[d], 1);
         check_eq("latency", cyc - t_in, lg * npts / 2 + 1);
         for (int k = 0; k < npts; k++) begin
            if (stall && k == 3) begin
               out_ready = 1'b0;
               start_v[d] = 1'b1;
               repeat (5) begin
                  @(posedge clk); #1;
                  check_eq("hold_valid", ov[d], 1);
                  check_eq("hold_idx", oidx[d], k);
                  check_eq("hold_re", ore[d], er[k]);
                  check_eq("hold_im", oim[d], ei[k]);
               end
               start_v[d] = 1'b0;
               out_ready = 1'b1;
            end
            check_eq("bin_valid", ov[d], 1);
            check_eq("bin_idx", oidx[d], k);
            check_eq($sformatf("bin%0d_re", k), ore[d], er[k]);
            check_eq($sformatf("bin%0d_im", k), oim[d], ei[k]);
            check_eq("no_early_done", done[d], 0);
            @(posedge clk); #1;
         end
         check_eq("done_pulse", done[d], 1);
         check_eq("busy_at_done", busy[d], 0);
         check_eq("valid_at_done", ov[d], 0);
         if (chain) begin
            start_v[d] = 1'b1;
            @(posedge clk); #1;
            start_v[d] = 1'b0;
         end else begin
            @(posedge clk); #1;
            check_eq("done_one_cycle", done[d], 0);
            check_eq("stays_idle", busy[d], 0);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      in_re = '0;
      in_im = '0;
      for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      for (int d = 0; d < 4; d++) begin
         check_eq($sformatf("rst_in_ready%0d", d), ir[d], 0);
         check_eq($sformatf("rst_valid%0d", d), ov[d], 0);
         check_eq($sformatf("rst_busy%0d", d), busy[d], 0);
         check_eq($sformatf("rst_done%0d", d), done[d], 0);
         check_eq($sformatf("rst_re%0d", d), ore[d], 0);
         check_eq($sformatf("rst_im%0d", d), oim[d], 0);
         check_eq($sformatf("rst_idx%0d", d), oidx[d], 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      test_name = "impulse8_s0";
      clear_vec();
      xr[0] = 1000;
      for (int i = 0; i < 8; i++) er[i] = 1000;
      run_fft(0, 3, 1'b0, 1'b0, 1'b0, 1'b0);

      test_name = "dc8_s1";
      clear_vec();
      for (int i = 0; i < 8; i++) xr[i] = 800;
      er[0] = 800;
      run_fft(1, 3, 1'b0, 1'b0, 1'b0, 1'b0);

      test_name = "alt8_s0";
      clear_vec();
      for (int i = 0; i < 8; i++) xr[i] = (i % 2 == 0) ? 100 : -100;
      er[4] = 800;
      run_fft(0, 3, 1'b0, 1'b0, 1'b1, 1'b0);

      test_name = "b2b_impulse8";
      clear_vec();
      xr[0] = 1000;
      for (int i = 0; i < 8; i++) er[i] = 1000;
      run_fft(0, 3, 1'b0, 1'b1, 1'b0, 1'b0);

      test_name = "x1_8_s0";
      clear_vec();
      xr[1] = 1000;
      er[0] = 1000;  ei[0] = 0;
      er[1] = 707;   ei[1] = -708;
      er[2] = 0;     ei[2] = -1000;
      er[3] = -708;  ei[3] = -708;
      er[4] = -1000; ei[4] = 0;
      er[5] = -707;  ei[5] = 708;
      er[6] = 0;     ei[6] = 1000;
      er[7] = 708;   ei[7] = 708;
      run_fft(0, 3, 1'b0, 1'b0, 1'b0, 1'b0);

      test_name = "x1_8_stall";
      run_fft(0, 3, 1'b1, 1'b0, 1'b0, 1'b0);

      test_name = "rst_mid_calc";
      run_fft(0, 3, 1'b0, 1'b0, 1'b0, 1'b1);

      test_name = "after_rst";
      run_fft(0, 3, 1'b0, 1'b0, 1'b0, 1'b0);

      test_name = "impulse4_w12";
      clear_vec();
      xr[0] = 1000;
      for (int i = 0; i < 4; i++) er[i] = 1000;
      run_fft(2, 2, 1'b0, 1'b0, 1'b0, 1'b0);

      test_name = "dc4_w12";
      clear_vec();
      for (int i = 0; i < 4; i++) xr[i] = 300;
      er[0] = 1200;
      run_fft(2, 2, 1'b0, 1'b0, 1'b0, 1'b0);

      test_name = "x1_4_w12";
      clear_vec();
      xr[1] = 100;
      er[0] = 100;  ei[0] = 0;
      er[1] = 0;    ei[1] = -100;
      er[2] = -100; ei[2] = 0;
      er[3] = 0;    ei[3] = 100;
      run_fft(2, 2, 1'b0, 1'b0, 1'b0, 1'b0);

      test_name = "wrap4_w12";
      clear_vec();
      for (int i = 0; i < 4; i++) xr[i] = 2047;
      er[0] = -4;
      run_fft(2, 2, 1'b0, 1'b0, 1'b0, 1'b0);

      test_name = "impulse16_s1";
      clear_vec();
      xr[0] = -1601;
      for (int i = 0; i < 16; i++) er[i] = -101;
      run_fft(3, 4, 1'b0, 1'b0, 1'b0, 1'b0);

      test_name = "dc16_s1";
      clear_vec();
      for (int i = 0; i < 16; i++) xr[i] = 800;
      er[0] = 800;
      run_fft(3, 4, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
